// File: rtl/battleship_turn_ctrl_pkg.sv
// battleship_pkg: FSM state encoding, coordinate type and status-bus bit positions
// shared by the turn controller, board RAM and display logic.
package battleship_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_PLAYER, S_CHK_P, S_PC, S_CHK_PC, S_OVER} state_t;
  localparam int COORD_W_DEF = 3;
  typedef logic [2*COORD_W_DEF-1:0] coord_t;
  localparam int ST_HIT     = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_WINNER  = 2;
  localparam int ST_OVER    = 3;
  localparam int ST_TURN    = 4;
  localparam int ST_STATE   = 5;
endpackage

// File: rtl/battleship_turn_ctrl_timer.sv
// turn_timer: per-turn down-counter; load restarts at TURN_CYCLES, en counts down to zero and holds.
module turn_timer #(
  parameter int TURN_CYCLES = 8,
  parameter int TIMER_W     = $clog2(TURN_CYCLES+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_en,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_zero
);
  logic [TIMER_W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= TIMER_W'(TURN_CYCLES);
    else if (i_en && !o_zero) r_count <= r_count - 1'b1;
  assign o_count = r_count;
  assign o_zero  = r_count == '0;
endmodule

// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl: placement, alternating turns, board lookup handshake, scoring and win detection.
// Turn timeout/forfeit exists only when BSHIP_TURN_TIMEOUT_EN is defined.
module battleship_turn_ctrl
  import battleship_pkg::*;
#(
  parameter int COORD_W     = 3,
  parameter int NUM_SHIPS   = 3,
  parameter int HITS_TO_WIN = 9,
  parameter int TURN_CYCLES = 50000000,
  parameter int HIT_REPEAT  = 1,
  localparam int SCORE_W    = $clog2(HITS_TO_WIN+1),
  localparam int TIMER_W    = $clog2(TURN_CYCLES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ship_done,
  input  logic                 fire,
  input  logic [2*COORD_W-1:0] fire_coord,
  input  logic                 pc_fire,
  input  logic [2*COORD_W-1:0] pc_coord,
  output logic                 shot_req,
  output logic [2*COORD_W-1:0] shot_coord,
  output logic                 shot_target,
  input  logic                 shot_ack,
  input  logic                 shot_hit,
  output logic [SCORE_W-1:0]   player_score,
  output logic [SCORE_W-1:0]   pc_score,
  output logic [TIMER_W-1:0]   timer_o,
  output logic [7:0]           status
);
  localparam int SHIP_W = $clog2(NUM_SHIPS+1);
  state_t r_state, w_next;
  logic [SHIP_W-1:0] r_ships;
  logic [2*COORD_W-1:0] r_coord;
  logic [SCORE_W-1:0] r_pscore, r_cscore, w_pinc, w_cinc;
  logic r_target, r_req, r_hit, r_winner, r_timeout;
  logic w_ack, w_chk, w_pturn, w_timeout;
`ifdef BSHIP_TURN_TIMEOUT_EN
  logic w_zero, w_turn, w_load;
  assign w_turn    = r_state == S_PLAYER || r_state == S_PC;
  assign w_load    = (w_next == S_PLAYER || w_next == S_PC) && w_next != r_state;
  assign w_timeout = w_turn && w_zero;
  turn_timer #(.TURN_CYCLES(TURN_CYCLES), .TIMER_W(TIMER_W)) u_timer (
    .clk(clk), .rst_n(rst), .i_load(w_load), .i_en(w_turn), .o_count(timer_o), .o_zero(w_zero)
  );
`else
  assign timer_o   = '0;
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_OVER: w_next = start ? S_PLACE : r_state;
      S_PLACE:  w_next = (ship_done && r_ships == SHIP_W'(NUM_SHIPS-1)) ? S_PLAYER : S_PLACE;
      S_PLAYER: w_next = w_timeout ? S_PC : fire ? S_CHK_P : S_PLAYER;
      S_PC:     w_next = w_timeout ? S_PLAYER : pc_fire ? S_CHK_PC : S_PC;
      S_CHK_P:  if (w_ack) w_next = (shot_hit && w_pinc == SCORE_W'(HITS_TO_WIN)) ? S_OVER :
                                    (shot_hit && HIT_REPEAT != 0) ? S_PLAYER : S_PC;
      S_CHK_PC: if (w_ack) w_next = (shot_hit && w_cinc == SCORE_W'(HITS_TO_WIN)) ? S_OVER :
                                    (shot_hit && HIT_REPEAT != 0) ? S_PC : S_PLAYER;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_ack   = r_req && shot_ack;
    w_chk   = r_state == S_CHK_P || r_state == S_CHK_PC;
    w_pturn = r_state == S_PLAYER || r_state == S_CHK_P;
    w_pinc  = r_pscore == SCORE_W'(HITS_TO_WIN) ? r_pscore : r_pscore + 1'b1;
    w_cinc  = r_cscore == SCORE_W'(HITS_TO_WIN) ? r_cscore : r_cscore + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ships   <= '0;
      r_coord   <= '0;
      r_pscore  <= '0;
      r_cscore  <= '0;
      r_target  <= 1'b0;
      r_req     <= 1'b0;
      r_hit     <= 1'b0;
      r_winner  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // request rises the cycle after entering a check state and drops after the ack cycle
      r_req     <= w_chk && !w_ack;
      r_timeout <= w_timeout;
      if (r_state == S_PLACE && ship_done) r_ships <= r_ships + 1'b1;
      if (w_next == S_PLACE && r_state != S_PLACE) begin
        r_ships  <= '0;
        r_pscore <= '0;
        r_cscore <= '0;
        r_winner <= 1'b0;
      end
      if (r_state == S_PLAYER && w_next == S_CHK_P) begin
        r_coord  <= fire_coord;
        r_target <= 1'b0;
      end
      if (r_state == S_PC && w_next == S_CHK_PC) begin
        r_coord  <= pc_coord;
        r_target <= 1'b1;
      end
      if (w_ack) r_hit <= shot_hit;
      if (w_ack && shot_hit && r_state == S_CHK_P) r_pscore <= w_pinc;
      if (w_ack && shot_hit && r_state == S_CHK_PC) r_cscore <= w_cinc;
      if (w_next == S_OVER && r_state != S_OVER) r_winner <= r_state == S_CHK_P;
    end
  assign shot_req     = r_req;
  assign shot_coord   = r_coord;
  assign shot_target  = r_target;
  assign player_score = r_pscore;
  assign pc_score     = r_cscore;
  always_comb begin
    status                 = '0;
    status[ST_STATE+:3]    = r_state;
    status[ST_TURN]        = w_pturn;
    status[ST_OVER]        = r_state == S_OVER;
    status[ST_WINNER]      = r_winner;
    status[ST_TIMEOUT]     = r_timeout;
    status[ST_HIT]         = r_hit;
  end
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// tb_battleship_turn_ctrl: directed checks of placement, shots, scoring, win, reset and timeout
// (timeout steps depend on BSHIP_TURN_TIMEOUT_EN); a second instance has HIT_REPEAT=0.
module tb_battleship_turn_ctrl;
  logic clk = 0, rst = 0, start = 0, ship_done = 0, fire = 0, pc_fire = 0, shot_ack = 0, shot_hit = 0;
  logic [5:0] fire_coord = '0, pc_coord = '0;
  logic shot_req, shot_target, d2_req, d2_target;
  logic [5:0] shot_coord, d2_coord;
  logic [1:0] player_score, pc_score, d2_pscore, d2_cscore;
  logic [3:0] timer_o, d2_timer;
  logic [7:0] status, d2_status;
  int checks = 0, failures = 0;
`ifdef BSHIP_TURN_TIMEOUT_EN
  localparam logic [31:0] T_LOAD = 8;
`else
  localparam logic [31:0] T_LOAD = 0;
`endif
  battleship_turn_ctrl #(.COORD_W(3), .NUM_SHIPS(3), .HITS_TO_WIN(2), .TURN_CYCLES(8), .HIT_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ship_done(ship_done), .fire(fire), .fire_coord(fire_coord),
    .pc_fire(pc_fire), .pc_coord(pc_coord), .shot_req(shot_req), .shot_coord(shot_coord),
    .shot_target(shot_target), .shot_ack(shot_ack), .shot_hit(shot_hit), .player_score(player_score),
    .pc_score(pc_score), .timer_o(timer_o), .status(status));
  battleship_turn_ctrl #(.COORD_W(3), .NUM_SHIPS(3), .HITS_TO_WIN(2), .TURN_CYCLES(8), .HIT_REPEAT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .ship_done(ship_done), .fire(fire), .fire_coord(fire_coord),
    .pc_fire(pc_fire), .pc_coord(pc_coord), .shot_req(d2_req), .shot_coord(d2_coord),
    .shot_target(d2_target), .shot_ack(shot_ack), .shot_hit(shot_hit), .player_score(d2_pscore),
    .pc_score(d2_cscore), .timer_o(d2_timer), .status(d2_status));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ack(input logic h);
    shot_ack = 1; shot_hit = h;
    tick(1);
    shot_ack = 0; shot_hit = 0;
  endtask
  task automatic place_ships();
    start = 1; tick(1); start = 0;
    ship_done = 1; tick(3); ship_done = 0;
  endtask
  task automatic player_shot(input logic [5:0] c, input logic h);
    fire_coord = c; fire = 1; tick(1); fire = 0;
    tick(1);
    ack(h);
  endtask
  initial begin
    #2;
    chk("rst_status", status, 8'h00);
    chk("rst_req", shot_req, 0);
    chk("rst_pscore", player_score, 0);
    chk("rst_timer", timer_o, 0);
    tick(2); rst = 1; tick(1);
    start = 1; tick(1); start = 0;
    chk("place_status", status, 8'h20);
    ship_done = 1; tick(3); ship_done = 0;
    chk("player_status", status, 8'h50);
    chk("player_timer", timer_o, T_LOAD);
    chk("player_req", shot_req, 0);
    pc_fire = 1; tick(1); pc_fire = 0;
    chk("pcfire_ignored", status, 8'h50);
    fire_coord = 6'o25; fire = 1; tick(1); fire = 0; fire_coord = 6'o00;
    chk("chkp_status", status, 8'h70);
    chk("chkp_entry_req", shot_req, 0);
    tick(1);
    chk("req_latency", shot_req, 1);
    chk("req_coord", shot_coord, 6'o25);
    chk("req_target", shot_target, 0);
    tick(2);
    chk("req_held", shot_req, 1);
    chk("coord_held", shot_coord, 6'o25);
    ack(1);
    chk("hit_pscore", player_score, 1);
    chk("hit_repeat_status", status, 8'h51);
    chk("req_dropped", shot_req, 0);
    chk("norepeat_status", d2_status, 8'h81);
    chk("norepeat_pscore", d2_pscore, 1);
    fire_coord = 6'o07; fire = 1; tick(1); fire = 0; tick(1);
    chk("miss_coord", shot_coord, 6'o07);
    ack(0);
    chk("miss_to_pc", status, 8'h80);
    chk("miss_pscore", player_score, 1);
    pc_coord = 6'o12; pc_fire = 1; tick(1); pc_fire = 0;
    chk("chkpc_status", status, 8'hA0);
    tick(1);
    chk("pc_req", shot_req, 1);
    chk("pc_target", shot_target, 1);
    chk("pc_coord", shot_coord, 6'o12);
    ack(1);
    chk("pc_hit_status", status, 8'h81);
    chk("pc_score1", pc_score, 1);
    pc_coord = 6'o13; pc_fire = 1; tick(1); pc_fire = 0; tick(1);
    ack(1);
    chk("pc_win_status", status, 8'hC9);
    chk("pc_score2", pc_score, 2);
    chk("over_pscore", player_score, 1);
    fire = 1; tick(1); fire = 0;
    chk("over_frozen", status, 8'hC9);
    start = 1; tick(1); start = 0;
    chk("restart_status", status, 8'h21);
    chk("restart_pscore", player_score, 0);
    chk("restart_cscore", pc_score, 0);
    ship_done = 1; tick(3); ship_done = 0;
    chk("g2_player", status, 8'h51);
    player_shot(6'o33, 1);
    chk("g2_hit", status, 8'h51);
    chk("g2_pscore", player_score, 1);
`ifdef BSHIP_TURN_TIMEOUT_EN
    chk("g2_timer_load", timer_o, 8);
    tick(8);
    chk("timer_zero", timer_o, 0);
    chk("timer_zero_state", status, 8'h51);
    fire = 1; tick(1); fire = 0;
    chk("timeout_to_pc", status, 8'h83);
    chk("timeout_reload", timer_o, 8);
    tick(1);
    chk("timeout_pulse_end", status, 8'h81);
    chk("timeout_no_req", shot_req, 0);
    tick(8);
    chk("pc_timeout", status, 8'h53);
`else
    tick(100);
    chk("no_timer", timer_o, 0);
    chk("no_forfeit", status, 8'h51);
`endif
    fire_coord = 6'o44; fire = 1; tick(1); fire = 0; tick(1);
    chk("pre_rst_req", shot_req, 1);
    rst = 0; #1;
    chk("async_rst_req", shot_req, 0);
    chk("async_rst_status", status, 8'h00);
    chk("async_rst_pscore", player_score, 0);
    chk("async_rst_timer", timer_o, 0);
    tick(1); rst = 1; tick(1);
    place_ships();
    chk("g3_player", status, 8'h50);
    player_shot(6'o01, 1);
    chk("g3_hit", status, 8'h51);
    player_shot(6'o02, 1);
    chk("player_win_status", status, 8'hCD);
    chk("player_win_score", player_score, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
